// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and control-word types for the ID/EX stage
//
// Purpose: ALUFun codes, datapath width defaults, and the control word that
//          travels from ID into EX (with its all-zero bubble value).
// Ports:   none (package).
package pipe_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int FW_DEF = 6;

  localparam logic [FW_DEF-1:0] ALU_ADD = 6'b000000;
  localparam logic [FW_DEF-1:0] ALU_SUB = 6'b000001;
  localparam logic [FW_DEF-1:0] ALU_AND = 6'b011000;
  localparam logic [FW_DEF-1:0] ALU_OR  = 6'b011110;
  localparam logic [FW_DEF-1:0] ALU_SLL = 6'b100000;
  localparam logic [FW_DEF-1:0] ALU_SRL = 6'b100001;
  localparam logic [FW_DEF-1:0] ALU_SRA = 6'b100011;
  localparam logic [FW_DEF-1:0] ALU_EQ  = 6'b110011;
  localparam logic [FW_DEF-1:0] ALU_LT  = 6'b110101;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic sign;
    logic alusrc1;
    logic alusrc2;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - signal bundle between ID, the forwarding sources and EX
//
// Purpose: groups the ID-side instruction fields, the EX/MEM and MEM/WB
//          forwarding taps, flush/hold, and the EX-side results.
// Modports: master - the surrounding pipeline (drives ID/forwarding/flush/hold)
//           slave  - the id_ex_stage block
interface id_ex_stage_if #(
  parameter int DW = pipe_pkg::DW_DEF,
  parameter int AW = pipe_pkg::AW_DEF,
  parameter int FW = pipe_pkg::FW_DEF
);

  logic          id_valid;
  logic [DW-1:0] id_pc;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] id_rd_dst;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_shamt;
  logic [FW-1:0] id_alufun;
  logic          id_sign;
  logic          id_alusrc1;
  logic          id_alusrc2;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_regwrite;
  logic          id_memread;
  logic          id_memwrite;
  logic          id_memtoreg;

  logic          exmem_regwrite;
  logic [AW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_regwrite;
  logic [AW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;

  logic          flush;
  logic          hold;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [FW-1:0] alu_fun;
  logic          alu_sign;
  logic [DW-1:0] ex_store_data;
  logic [DW-1:0] ex_pc;
  logic [AW-1:0] ex_rd;
  logic          ex_valid;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_memtoreg;
  logic          load_use_stall;

  modport master (
    output id_valid, id_pc, id_rs, id_rt, id_rd_dst, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_alufun, id_sign, id_alusrc1, id_alusrc2,
           id_use_rs, id_use_rt, id_regwrite, id_memread, id_memwrite, id_memtoreg,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result, flush, hold,
    input  alu_a, alu_b, alu_fun, alu_sign, ex_store_data, ex_pc, ex_rd,
           ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs, id_rt, id_rd_dst, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_alufun, id_sign, id_alusrc1, id_alusrc2,
           id_use_rs, id_use_rt, id_regwrite, id_memread, id_memwrite, id_memtoreg,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result, flush, hold,
    output alu_a, alu_b, alu_fun, alu_sign, ex_store_data, ex_pc, ex_rd,
           ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - operand forwarding comparator and mux
//
// Purpose: picks the freshest value of one source register: EX/MEM result,
//          else MEM/WB result, else the latched register-file data.
// Ports:   src (register number), rf_data (latched read data),
//          exmem_* / memwb_* forwarding taps, data (selected operand).
module fwd_mux #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic [DW-1:0] rf_data,
  input  logic          exmem_regwrite,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] data
);

  logic hit_exmem;
  logic hit_memwb;

  // $0 is hardwired zero, so a write to it must never shadow the RF value.
  assign hit_exmem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src);
  assign hit_memwb = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src);

  // EX/MEM is younger than MEM/WB, so it takes precedence.
  always_comb begin
    data = rf_data;
    if (hit_exmem)      data = exmem_result;
    else if (hit_memwb) data = memwb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and hazard control
//
// Purpose: latches the decoded ID instruction, forwards EX/MEM and MEM/WB
//          results into the ALU operands, detects load-use hazards and
//          inserts bubbles for load-use, branch flush and deferred flush.
// Ports:   clk   - pipeline clock, rising edge
//          reset - asynchronous active-low reset
//          bus   - id_ex_stage_if.slave: ID fields, forwarding taps,
//                  flush/hold in; ALU operands, EX control, stall out
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  id_ex_stage_if.slave   bus
);

  ctrl_t         ex_ctrl;
  ctrl_t         id_ctrl;
  logic [DW-1:0] ex_pc_q;
  logic [AW-1:0] ex_rs;
  logic [AW-1:0] ex_rt;
  logic [AW-1:0] ex_rd_q;
  logic [DW-1:0] ex_rs_data;
  logic [DW-1:0] ex_rt_data;
  logic [DW-1:0] ex_imm;
  logic [4:0]    ex_shamt;
  logic [FW-1:0] ex_alufun;
  logic          flush_pending;
  logic          load_use_stall;
  logic          bubble;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // An invalid ID slot must not carry side effects into EX.
  always_comb begin
    id_ctrl          = BUBBLE_CTRL;
    id_ctrl.valid    = bus.id_valid;
    id_ctrl.regwrite = bus.id_valid & bus.id_regwrite;
    id_ctrl.memread  = bus.id_valid & bus.id_memread;
    id_ctrl.memwrite = bus.id_valid & bus.id_memwrite;
    id_ctrl.memtoreg = bus.id_valid & bus.id_memtoreg;
    id_ctrl.sign     = bus.id_sign;
    id_ctrl.alusrc1  = bus.id_alusrc1;
    id_ctrl.alusrc2  = bus.id_alusrc2;
  end

  // A load in EX cannot forward until MEM; the consumer in ID waits a cycle.
  // Suppressed under hold because nothing moves that cycle anyway.
  always_comb begin
    load_use_stall = 1'b0;
    if (!bus.hold && ex_ctrl.valid && ex_ctrl.memread && (ex_rd_q != '0) && bus.id_valid)
      load_use_stall = (bus.id_use_rs && (bus.id_rs == ex_rd_q)) ||
                       (bus.id_use_rt && (bus.id_rt == ex_rd_q));
  end

  assign bubble = bus.flush | flush_pending | load_use_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_ctrl       <= BUBBLE_CTRL;
      ex_pc_q       <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd_q       <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_shamt      <= '0;
      ex_alufun     <= '0;
      flush_pending <= 1'b0;
    end else if (bus.hold) begin
      // A taken branch during a downstream stall is remembered and applied
      // on the first edge that actually advances the pipe.
      if (bus.flush) flush_pending <= 1'b1;
    end else begin
      flush_pending <= 1'b0;
      // Datapath fields load unconditionally; a bubble is defined purely by
      // its zeroed control, destination and function code.
      ex_pc_q    <= bus.id_pc;
      ex_rs      <= bus.id_rs;
      ex_rt      <= bus.id_rt;
      ex_rs_data <= bus.id_rs_data;
      ex_rt_data <= bus.id_rt_data;
      ex_imm     <= bus.id_imm;
      ex_shamt   <= bus.id_shamt;
      if (bubble) begin
        ex_ctrl   <= BUBBLE_CTRL;
        ex_rd_q   <= '0;
        ex_alufun <= '0;
      end else begin
        ex_ctrl   <= id_ctrl;
        ex_rd_q   <= bus.id_rd_dst;
        ex_alufun <= bus.id_alufun;
      end
    end
  end

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
    .src            (ex_rs),
    .rf_data        (ex_rs_data),
    .exmem_regwrite (bus.exmem_regwrite),
    .exmem_rd       (bus.exmem_rd),
    .exmem_result   (bus.exmem_result),
    .memwb_regwrite (bus.memwb_regwrite),
    .memwb_rd       (bus.memwb_rd),
    .memwb_result   (bus.memwb_result),
    .data           (fwd_rs)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
    .src            (ex_rt),
    .rf_data        (ex_rt_data),
    .exmem_regwrite (bus.exmem_regwrite),
    .exmem_rd       (bus.exmem_rd),
    .exmem_result   (bus.exmem_result),
    .memwb_regwrite (bus.memwb_regwrite),
    .memwb_rd       (bus.memwb_rd),
    .memwb_result   (bus.memwb_result),
    .data           (fwd_rt)
  );

  // Shifts put the shift amount on A and the value being shifted on B.
  assign bus.alu_a          = ex_ctrl.alusrc1 ? {{(DW-5){1'b0}}, ex_shamt} : fwd_rs;
  assign bus.alu_b          = ex_ctrl.alusrc2 ? ex_imm : fwd_rt;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.alu_fun        = ex_alufun;
  assign bus.alu_sign       = ex_ctrl.sign;
  assign bus.ex_pc          = ex_pc_q;
  assign bus.ex_rd          = ex_rd_q;
  assign bus.ex_valid       = ex_ctrl.valid;
  assign bus.ex_regwrite    = ex_ctrl.regwrite;
  assign bus.ex_memread     = ex_ctrl.memread;
  assign bus.ex_memwrite    = ex_ctrl.memwrite;
  assign bus.ex_memtoreg    = ex_ctrl.memtoreg;
  assign bus.load_use_stall = load_use_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic valid; logic [31:0] pc; logic [4:0] rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm; logic [4:0] shamt; logic [5:0] alufun;
    logic sign, alusrc1, alusrc2, use_rs, use_rt;
    logic regwrite, memread, memwrite, memtoreg;
    logic exw; logic [4:0] exrd; logic [31:0] exres;
    logic mww; logic [4:0] mwrd; logic [31:0] mwres;
    logic flush, hold;
  } stim_t;

  typedef struct {
    logic valid; logic [31:0] pc; logic [4:0] rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm; logic [4:0] shamt; logic [5:0] alufun;
    logic sign, alusrc1, alusrc2, regwrite, memread, memwrite, memtoreg;
  } ex_t;

  typedef struct {
    logic [31:0] a, b, store, pc; logic [4:0] rd; logic [5:0] fun;
    logic sign, valid, rw, mr, mw, mtr, stall;
  } exp_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 0;
  exp_t  exp_q[$];
  ex_t   m;
  bit    m_fp;
  stim_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf, input stim_t s);
    if (s.exw && s.exrd != 0 && s.exrd == src) return s.exres;
    if (s.mww && s.mwrd != 0 && s.mwrd == src) return s.mwres;
    return rf;
  endfunction

  function automatic bit model_stall(input ex_t e, input stim_t s);
    if (s.hold) return 1'b0;
    return e.valid && e.memread && e.rd != 0 && s.valid &&
           ((s.use_rs && s.rs == e.rd) || (s.use_rt && s.rt == e.rd));
  endfunction

  // Advance the reference EX slot by one clock using the inputs applied this cycle.
  task automatic model_edge();
    bit st;
    st = model_stall(m, cur);
    if (cur.hold) begin
      if (cur.flush) m_fp = 1;
    end else if (cur.flush || m_fp || st) begin
      m.valid = 0; m.regwrite = 0; m.memread = 0; m.memwrite = 0; m.memtoreg = 0;
      m.rd = 0; m.alufun = 0;
      m_fp = 0;
    end else begin
      m.valid = cur.valid; m.pc = cur.pc; m.rs = cur.rs; m.rt = cur.rt; m.rd = cur.rd;
      m.rs_data = cur.rs_data; m.rt_data = cur.rt_data; m.imm = cur.imm;
      m.shamt = cur.shamt; m.alufun = cur.alufun; m.sign = cur.sign;
      m.alusrc1 = cur.alusrc1; m.alusrc2 = cur.alusrc2;
      m.regwrite = cur.valid & cur.regwrite; m.memread = cur.valid & cur.memread;
      m.memwrite = cur.valid & cur.memwrite; m.memtoreg = cur.valid & cur.memtoreg;
    end
  endtask

  task automatic drive(input stim_t s);
    bus.id_valid = s.valid; bus.id_pc = s.pc; bus.id_rs = s.rs; bus.id_rt = s.rt;
    bus.id_rd_dst = s.rd; bus.id_rs_data = s.rs_data; bus.id_rt_data = s.rt_data;
    bus.id_imm = s.imm; bus.id_shamt = s.shamt; bus.id_alufun = s.alufun;
    bus.id_sign = s.sign; bus.id_alusrc1 = s.alusrc1; bus.id_alusrc2 = s.alusrc2;
    bus.id_use_rs = s.use_rs; bus.id_use_rt = s.use_rt; bus.id_regwrite = s.regwrite;
    bus.id_memread = s.memread; bus.id_memwrite = s.memwrite; bus.id_memtoreg = s.memtoreg;
    bus.exmem_regwrite = s.exw; bus.exmem_rd = s.exrd; bus.exmem_result = s.exres;
    bus.memwb_regwrite = s.mww; bus.memwb_rd = s.mwrd; bus.memwb_result = s.mwres;
    bus.flush = s.flush; bus.hold = s.hold;
  endtask

  task automatic cycle(input stim_t s);
    exp_t e;
    logic [31:0] fr, ft;
    @(posedge clk);
    model_edge();
    #1;
    cur = s;
    drive(s);
    fr = fwd(m.rs, m.rs_data, s);
    ft = fwd(m.rt, m.rt_data, s);
    e.a = m.alusrc1 ? {27'b0, m.shamt} : fr;
    e.b = m.alusrc2 ? m.imm : ft;
    e.store = ft; e.pc = m.pc; e.rd = m.rd; e.fun = m.alufun; e.sign = m.sign;
    e.valid = m.valid; e.rw = m.regwrite; e.mr = m.memread; e.mw = m.memwrite;
    e.mtr = m.memtoreg; e.stall = model_stall(m, s);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ex_valid", bus.ex_valid, e.valid);
      check("ex_regwrite", bus.ex_regwrite, e.rw);
      check("ex_memread", bus.ex_memread, e.mr);
      check("ex_memwrite", bus.ex_memwrite, e.mw);
      check("ex_memtoreg", bus.ex_memtoreg, e.mtr);
      check("ex_rd", bus.ex_rd, e.rd);
      check("alu_fun", bus.alu_fun, e.fun);
      check("load_use_stall", bus.load_use_stall, e.stall);
      if (e.valid) begin
        check("alu_a", bus.alu_a, e.a);
        check("alu_b", bus.alu_b, e.b);
        check("ex_store_data", bus.ex_store_data, e.store);
        check("ex_pc", bus.ex_pc, e.pc);
        check("alu_sign", bus.alu_sign, e.sign);
      end
    end
  end

  function automatic stim_t rand_stim(input bit keep_id);
    stim_t s;
    s = cur;
    if (!keep_id) begin
      s.valid = ($urandom_range(0, 9) != 0);
      s.pc = $urandom; s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 7)); s.rs_data = $urandom; s.rt_data = $urandom;
      s.imm = $urandom; s.shamt = 5'($urandom); s.alufun = 6'($urandom);
      s.sign = 1'($urandom); s.alusrc1 = ($urandom_range(0, 4) == 0);
      s.alusrc2 = 1'($urandom); s.use_rs = 1'($urandom); s.use_rt = 1'($urandom);
      s.regwrite = 1'($urandom); s.memread = ($urandom_range(0, 2) == 0);
      s.memwrite = 1'($urandom); s.memtoreg = 1'($urandom);
    end
    s.exw = 1'($urandom); s.exrd = 5'($urandom_range(0, 7)); s.exres = $urandom;
    s.mww = 1'($urandom); s.mwrd = 5'($urandom_range(0, 7)); s.mwres = $urandom;
    s.flush = ($urandom_range(0, 9) == 0);
    s.hold  = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  task automatic random_phase(input int n);
    bit keep;
    for (int i = 0; i < n; i++) begin
      keep = cur.hold || model_stall(m, cur);
      cycle(rand_stim(keep));
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    mon_en = 0;
    exp_q.delete();
    reset = 1'b0;
    #1;
    check("rst_alu_a", bus.alu_a, 32'h0);
    check("rst_alu_b", bus.alu_b, 32'h0);
    check("rst_store", bus.ex_store_data, 32'h0);
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_ex_rd", bus.ex_rd, 5'd0);
    check("rst_alu_fun", bus.alu_fun, 6'd0);
    check("rst_ex_pc", bus.ex_pc, 32'h0);
    check("rst_stall", bus.load_use_stall, 1'b0);
    m = '{default: '0};
    m_fp = 0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_release_valid", bus.ex_valid, 1'b0);
    mon_en = 1;
  endtask

  initial begin
    stim_t s;
    m = '{default: '0};
    m_fp = 0;
    cur = nop();
    drive(cur);
    #2;
    check("init_alu_a", bus.alu_a, 32'h0);
    check("init_alu_b", bus.alu_b, 32'h0);
    check("init_alu_fun", bus.alu_fun, 6'd0);
    check("init_stall", bus.load_use_stall, 1'b0);
    check("init_ex_valid", bus.ex_valid, 1'b0);
    #10;
    reset = 1'b1;
    mon_en = 1;

    // EX/MEM forward: add $3 then sub $4,$3,$2
    s = nop(); s.valid = 1; s.rs = 1; s.rt = 2; s.rd = 3; s.use_rs = 1; s.use_rt = 1;
    s.regwrite = 1; s.alufun = ALU_ADD; cycle(s);
    s = nop(); s.valid = 1; s.rs = 3; s.rt = 2; s.rd = 4; s.rs_data = 32'h5; s.rt_data = 32'h3;
    s.use_rs = 1; s.use_rt = 1; s.regwrite = 1; s.alufun = ALU_SUB; cycle(s);
    s = nop(); s.exw = 1; s.exrd = 3; s.exres = 32'h10; cycle(s);
    #2;
    check("exmem_fwd_a", bus.alu_a, 32'h10);
    check("exmem_fwd_b", bus.alu_b, 32'h3);
    check("exmem_fwd_fun", bus.alu_fun, ALU_SUB);

    // Both stages match: EX/MEM wins
    s = nop(); s.valid = 1; s.rs = 3; s.rd = 9; s.rs_data = 32'h55; s.use_rs = 1; cycle(s);
    s = nop(); s.exw = 1; s.exrd = 3; s.exres = 32'hA; s.mww = 1; s.mwrd = 3; s.mwres = 32'hB;
    cycle(s);
    #2;
    check("double_hazard_a", bus.alu_a, 32'hA);

    // $0 never forwarded
    s = nop(); s.valid = 1; s.rs = 0; s.rd = 9; s.rs_data = 32'h77; s.use_rs = 1; cycle(s);
    s = nop(); s.exw = 1; s.exrd = 0; s.exres = 32'hDEAD; s.mww = 1; s.mwrd = 0; s.mwres = 32'hBEEF;
    cycle(s);
    #2;
    check("reg0_no_fwd", bus.alu_a, 32'h77);

    // Load-use: lw $5 then add $6,$5,$1
    s = nop(); s.valid = 1; s.rs = 1; s.rd = 5; s.use_rs = 1; s.memread = 1; s.regwrite = 1;
    s.memtoreg = 1; s.alusrc2 = 1; s.imm = 32'h4; cycle(s);
    s = nop(); s.valid = 1; s.rs = 5; s.rt = 1; s.rd = 6; s.use_rs = 1; s.use_rt = 1;
    s.regwrite = 1; s.alufun = ALU_ADD; cycle(s);
    #2;
    check("lu_stall", bus.load_use_stall, 1'b1);
    cycle(s);
    #2;
    check("lu_bubble_valid", bus.ex_valid, 1'b0);
    check("lu_bubble_stall", bus.load_use_stall, 1'b0);
    cycle(nop());
    #2;
    check("lu_add_valid", bus.ex_valid, 1'b1);
    check("lu_add_rd", bus.ex_rd, 5'd6);

    // Shift: sll $2,$7,4 with $7 from MEM/WB
    s = nop(); s.valid = 1; s.rt = 7; s.rd = 2; s.shamt = 4; s.alusrc1 = 1; s.use_rt = 1;
    s.rt_data = 32'h99; s.regwrite = 1; s.alufun = ALU_SLL; cycle(s);
    s = nop(); s.mww = 1; s.mwrd = 7; s.mwres = 32'h1; cycle(s);
    #2;
    check("sll_a", bus.alu_a, 32'h4);
    check("sll_b", bus.alu_b, 32'h1);
    check("sll_fun", bus.alu_fun, ALU_SLL);

    // Flush during hold is deferred until hold drops
    s = nop(); s.valid = 1; s.rs = 1; s.rd = 8; s.regwrite = 1; s.pc = 32'h100; cycle(s);
    s.hold = 1; s.flush = 1; s.pc = 32'h200; cycle(s);
    #2;
    check("fh_loaded_pc", bus.ex_pc, 32'h100);
    s = nop(); s.valid = 1; s.rd = 10; s.regwrite = 1; s.pc = 32'h300; cycle(s);
    #2;
    check("fh_frozen_valid", bus.ex_valid, 1'b1);
    check("fh_frozen_pc", bus.ex_pc, 32'h100);
    cycle(s);
    #2;
    check("fh_bubble_valid", bus.ex_valid, 1'b0);
    cycle(nop());
    #2;
    check("fh_resume_valid", bus.ex_valid, 1'b1);
    check("fh_resume_pc", bus.ex_pc, 32'h300);

    random_phase(400);
    mid_reset();
    random_phase(400);
    cycle(nop());
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select/forwarding stage for the 5-stage MIPS pipeline.
- Latches decoded instruction fields, register-file data and control from ID.
- Resolves EX/MEM and MEM/WB forwarding and produces the ALU inputs (A, B, ALUFun, Sign) plus the control carried into EX/MEM.
- Detects load-use hazards, inserts bubbles, and handles branch flush and downstream hold.

Parameters:
- DW, 32, datapath width.
- AW, 5, register-address width.
- FW, 6, ALUFun width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  DW  PC of the ID instruction.
- id_rs, id_rt  in  AW  source register numbers.
- id_rd_dst  in  AW  destination register, already selected.
- id_rs_data, id_rt_data  in  DW  register-file read data.
- id_imm  in  DW  extended immediate.
- id_shamt  in  5  shift amount.
- id_alufun  in  FW  ALU function code.
- id_sign  in  1  signed compare/overflow select.
- id_alusrc1  in  1  A select: 0=rs, 1=shamt.
- id_alusrc2  in  1  B select: 0=rt, 1=imm.
- id_use_rs, id_use_rt  in  1  instruction reads rs / rt.
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  control bits.
- exmem_regwrite  in  1  EX/MEM writes a register.
- exmem_rd  in  AW  EX/MEM destination register.
- exmem_result  in  DW  EX/MEM ALU result.
- memwb_regwrite  in  1  MEM/WB writes a register.
- memwb_rd  in  AW  MEM/WB destination register.
- memwb_result  in  DW  MEM/WB writeback value.
- flush  in  1  branch/jump taken; kill the ID instruction.
- hold  in  1  downstream stall; freeze this stage.
- alu_a, alu_b  out  DW  ALU operands.
- alu_fun  out  FW  ALU function code.
- alu_sign  out  1  ALU sign select.
- ex_store_data  out  DW  forwarded rt value for stores.
- ex_pc  out  DW  PC of the EX instruction.
- ex_rd  out  AW  EX destination register.
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  registered control.
- load_use_stall  out  1  freeze PC and IF/ID this cycle.

Behaviour:
- Reset (reset=0, asynchronous): every register clears to 0, flush_pending=0. With zero operands and ALUFun=000000, alu_a=alu_b=0, alu_fun=0, load_use_stall=0.
- Latency: one cycle from ID inputs to registered EX fields. alu_a, alu_b and ex_store_data are combinational from the registers and the forwarding inputs.
- Load-use hazard: load_use_stall = ex_valid & ex_memread & ex_rd!=0 & id_valid & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)). It is combinational and forced to 0 while hold=1.
- Per-edge priority, evaluated in order:
  - hold=1: all registers retain their values. A flush seen during hold sets flush_pending=1.
  - flush=1, or flush_pending=1: load a bubble (ex_valid and all control bits 0, ex_rd=0, alu_fun=0) and clear flush_pending.
  - load_use_stall=1: load a bubble. The ID inputs stay stable because upstream holds them.
  - otherwise: load all ID fields, with ex_valid=id_valid. When id_valid=0, the control bits are zeroed.
- Forwarding, applied separately for rs and for rt (forwarded value fwd_rs / fwd_rt):
  - If exmem_regwrite and exmem_rd!=0 and exmem_rd equals the source, take exmem_result.
  - Else if memwb_regwrite and memwb_rd!=0 and memwb_rd matches, take memwb_result.
  - Else take the latched register-file data.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- Operand select:
  - alu_a = alusrc1 ? {27'b0, shamt} : fwd_rs (shift amount goes on A, shifted value on B).
  - alu_b = alusrc2 ? imm : fwd_rt.
  - ex_store_data = fwd_rt, regardless of alusrc2.
- alu_fun and alu_sign pass through from the registered fields unchanged.
- A load sitting in EX/MEM is never forwarded from exmem_result; the load-use bubble guarantees this.

Decomposition:
- Package pipe_pkg holds:
  - ALUFun constants: ADD 000000, SUB 000001, AND 011000, OR 011110, SLL 100000, SRL 100001, SRA 100011, EQ 110011, LT 110101.
  - DW/AW defaults.
  - The bubble control-word constant.
- One sub-module, fwd_mux: a forwarding comparator and mux, instantiated twice (rs and rt).

Test Plan:
- Reset: assert reset=0 mid-run with the registers loaded → all outputs 0 immediately, asynchronously; ex_valid=0 after release.
- EX/MEM forward: add $3 in EX/MEM with exmem_result=0x00000010; next instruction in ID is sub $4,$3,$2 with rf $3=0x5, $2=0x3 → alu_a=0x10, alu_b=0x3, alu_fun=000001.
- Double hazard and $0 rule:
  - exmem_rd=memwb_rd=3 with results 0xA and 0xB → alu_a=0xA.
  - exmem_rd=0 with regwrite=1 → no forward; register-file value used.
- Load-use: lw $5 in EX (memread=1, ex_rd=5); ID add $6,$5,$1 → load_use_stall=1 for one cycle, bubble enters (ex_valid=0), add enters EX on the following edge.
- Shift: sll $2,$7,4 with forwarded $7=0x1 from MEM/WB → alu_a=0x4, alu_b=0x1, alu_fun=100000.
- Flush under hold: hold=1 with flush=1 for one cycle → registers frozen; after hold drops, ex_valid=0 for one cycle, then normal flow.
